// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async_fifo write port among NUM_REQ wr_clk requesters.
// Grant is taken one cycle after a request is seen in IDLE. Writes are gated combinationally by fifo_full, which stalls but never releases a grant.
module fifo_wr_arbiter #(
   parameter  int DATA_WIDTH = 4,
   parameter  int NUM_REQ    = 4,
   parameter  int MAX_BURST  = 4,
   localparam int GNT_W      = $clog2(NUM_REQ),
   localparam int CNT_W      = $clog2(MAX_BURST + 1)
) (
   input  logic                          wr_clk,
   input  logic                          wr_rst_n,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic                          fifo_full_i,
   output logic                          fifo_wr_en_o,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
   output logic                          gnt_valid_o,
   output logic [GNT_W-1:0]              gnt_id_o
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state_q, state_d;
   logic [GNT_W-1:0] gnt_id_q, gnt_id_d;
   logic [GNT_W-1:0] last_gnt_q, last_gnt_d;
   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   logic [GNT_W-1:0] pick_id, cand;
   logic             pick_found;
   logic             xfer;

   assign xfer = (state_q == GRANT) && req_valid_i[gnt_id_q] && !fifo_full_i;

   // Search starts one past the last granted requester, wrapping.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      cand       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = GNT_W'((int'(last_gnt_q) + k) % NUM_REQ);
         if (!pick_found && req_valid_i[cand]) begin
            pick_found = 1'b1;
            pick_id    = cand;
         end
      end
   end

   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         state_q     <= IDLE;
         gnt_id_q    <= '0;
         last_gnt_q  <= GNT_W'(NUM_REQ - 1);
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         gnt_id_q    <= gnt_id_d;
         last_gnt_q  <= last_gnt_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      gnt_id_d    = gnt_id_q;
      last_gnt_d  = last_gnt_q;
      burst_cnt_d = burst_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (pick_found && !fifo_full_i) begin
               state_d     = GRANT;
               gnt_id_d    = pick_id;
               burst_cnt_d = '0;
            end
         end
         GRANT: begin
            if (!req_valid_i[gnt_id_q] ||
                (xfer && burst_cnt_q == CNT_W'(MAX_BURST - 1))) begin
               state_d     = IDLE;
               last_gnt_d  = gnt_id_q;
               burst_cnt_d = '0;
            end else if (xfer) begin
               burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fifo_wr_en_o   = xfer;
      fifo_wr_data_o = '0;
      req_ready_o    = '0;
      if (xfer) begin
         fifo_wr_data_o = req_data_i[gnt_id_q*DATA_WIDTH +: DATA_WIDTH];
         req_ready_o    = NUM_REQ'(1) << gnt_id_q;
      end
      gnt_valid_o = (state_q == GRANT);
      gnt_id_o    = gnt_id_q;
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: inputs change 1ns after posedge, outputs sampled at negedge.
module tb_fifo_wr_arbiter;

   logic        wr_clk;
   logic        wr_rst_n;
   logic [3:0]  req_valid;
   logic [15:0] req_data;
   logic [3:0]  req_ready;
   logic        fifo_full;
   logic        fifo_wr_en;
   logic [3:0]  fifo_wr_data;
   logic        gnt_valid;
   logic [1:0]  gnt_id;

   logic [3:0]  word [4];
   logic        s_en, s_gv;
   logic [3:0]  s_dat, s_rdy;
   logic [1:0]  s_gid;
   int          checks = 0;
   int          errors = 0;

   fifo_wr_arbiter #(.DATA_WIDTH(4), .NUM_REQ(4), .MAX_BURST(4)) dut (
      .wr_clk         (wr_clk),
      .wr_rst_n       (wr_rst_n),
      .req_valid_i    (req_valid),
      .req_data_i     (req_data),
      .req_ready_o    (req_ready),
      .fifo_full_i    (fifo_full),
      .fifo_wr_en_o   (fifo_wr_en),
      .fifo_wr_data_o (fifo_wr_data),
      .gnt_valid_o    (gnt_valid),
      .gnt_id_o       (gnt_id)
   );

   initial wr_clk = 1'b0;
   always #5 wr_clk = ~wr_clk;

   always_comb begin
      req_data = '0;
      for (int i = 0; i < 4; i++) req_data[i*4 +: 4] = word[i];
   end

   // Sample this cycle's outputs, then step to just after the next posedge; accepted words advance.
   task automatic tick();
      @(negedge wr_clk);
      s_en  = fifo_wr_en;
      s_dat = fifo_wr_data;
      s_rdy = req_ready;
      s_gv  = gnt_valid;
      s_gid = gnt_id;
      @(posedge wr_clk);
      #1;
      for (int i = 0; i < 4; i++) if (s_rdy[i]) word[i] = word[i] + 4'd1;
   endtask

   task automatic reset_dut();
      wr_rst_n  = 1'b0;
      req_valid = '0;
      fifo_full = 1'b0;
      tick();
      wr_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      wr_rst_n  = 1'b0;
      req_valid = 4'hF;
      fifo_full = 1'b0;
      for (int i = 0; i < 4; i++) word[i] = 4'(i + 1);
      @(posedge wr_clk);
      #1;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (s_en !== 1'b0 || s_rdy !== 4'h0 || s_gv !== 1'b0 || s_dat !== 4'h0) begin
            errors++;
            $display("FAIL reset_hold en=%b rdy=%h gv=%b dat=%h expected 0 0 0 0", s_en, s_rdy, s_gv, s_dat);
         end
      end
      wr_rst_n = 1'b1;
      tick();
      checks++;
      if (s_gv !== 1'b0 || s_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_idle gv=%b en=%b expected 0 0", s_gv, s_en);
      end
      tick();
      checks++;
      if (s_gv !== 1'b1 || s_gid !== 2'd0) begin
         errors++;
         $display("FAIL reset_first_grant gv=%b id=%0d expected 1 0", s_gv, s_gid);
      end
   endtask

   task automatic test_burst_limit();
      logic [10:0] exp_en;
      logic [3:0]  exp_dat [11];
      exp_en  = 11'b01111011110;
      exp_dat = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0};
      reset_dut();
      word[0]   = 4'd1;
      req_valid = 4'b0001;
      for (int c = 0; c < 11; c++) begin
         tick();
         checks++;
         if (s_en !== exp_en[c] || s_dat !== exp_dat[c] || s_gv !== exp_en[c]) begin
            errors++;
            $display("FAIL burst_c%0d en=%b dat=%h gv=%b expected %b %h %b",
                     c, s_en, s_dat, s_gv, exp_en[c], exp_dat[c], exp_en[c]);
         end
      end
      req_valid = '0;
   endtask

   task automatic test_round_robin();
      logic [1:0] order [5];
      logic [3:0] base  [5];
      logic [3:0] ed;
      logic [3:0] er;
      order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      base  = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd4};
      reset_dut();
      for (int i = 0; i < 4; i++) word[i] = 4'(i * 4);
      req_valid = 4'hF;
      for (int g = 0; g < 5; g++) begin
         tick();
         checks++;
         if (s_gv !== 1'b0 || s_en !== 1'b0) begin
            errors++;
            $display("FAIL rr_bubble_g%0d gv=%b en=%b expected 0 0", g, s_gv, s_en);
         end
         for (int n = 0; n < 4; n++) begin
            ed = base[g] + 4'(n);
            er = 4'b0001 << order[g];
            tick();
            checks++;
            if (s_gv !== 1'b1 || s_gid !== order[g]) begin
               errors++;
               $display("FAIL rr_gnt_g%0d_n%0d gv=%b id=%0d expected 1 %0d", g, n, s_gv, s_gid, order[g]);
            end
            checks++;
            if (s_en !== 1'b1 || s_dat !== ed || s_rdy !== er) begin
               errors++;
               $display("FAIL rr_wr_g%0d_n%0d en=%b dat=%h rdy=%b expected 1 %h %b", g, n, s_en, s_dat, s_rdy, ed, er);
            end
         end
      end
      req_valid = '0;
   endtask

   task automatic test_full_stall();
      logic [3:0] exp_dat [4];
      exp_dat = '{4'd1, 4'd2, 4'd3, 4'd4};
      reset_dut();
      word[0]   = 4'd1;
      req_valid = 4'b0001;
      fifo_full = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (s_gv !== 1'b0 || s_en !== 1'b0) begin
            errors++;
            $display("FAIL full_idle_c%0d gv=%b en=%b expected 0 0", c, s_gv, s_en);
         end
      end
      fifo_full = 1'b0;
      tick();
      for (int n = 0; n < 4; n++) begin
         if (n == 2) begin
            fifo_full = 1'b1;
            for (int s = 0; s < 3; s++) begin
               tick();
               checks++;
               if (s_en !== 1'b0 || s_rdy !== 4'h0 || s_gv !== 1'b1 || s_gid !== 2'd0 || s_dat !== 4'h0) begin
                  errors++;
                  $display("FAIL full_stall_s%0d en=%b rdy=%h gv=%b id=%0d dat=%h expected 0 0 1 0 0",
                           s, s_en, s_rdy, s_gv, s_gid, s_dat);
               end
            end
            fifo_full = 1'b0;
         end
         tick();
         checks++;
         if (s_en !== 1'b1 || s_dat !== exp_dat[n] || s_gid !== 2'd0) begin
            errors++;
            $display("FAIL full_wr_n%0d en=%b dat=%h id=%0d expected 1 %h 0", n, s_en, s_dat, s_gid, exp_dat[n]);
         end
      end
      tick();
      checks++;
      if (s_gv !== 1'b0 || s_en !== 1'b0) begin
         errors++;
         $display("FAIL full_release gv=%b en=%b expected 0 0", s_gv, s_en);
      end
      req_valid = '0;
   endtask

   task automatic test_early_release();
      logic [3:0] masks [2];
      logic [1:0] nxt   [2];
      masks = '{4'b1001, 4'b0001};
      nxt   = '{2'd3, 2'd0};
      for (int v = 0; v < 2; v++) begin
         reset_dut();
         word[2]   = 4'd5;
         req_valid = 4'b0100;
         tick();
         for (int n = 0; n < 2; n++) begin
            tick();
            checks++;
            if (s_en !== 1'b1 || s_gid !== 2'd2 || s_dat !== 4'(5 + n)) begin
               errors++;
               $display("FAIL early_wr_v%0d_n%0d en=%b id=%0d dat=%h expected 1 2 %0d", v, n, s_en, s_gid, s_dat, 5 + n);
            end
         end
         req_valid = masks[v];
         tick();
         checks++;
         if (s_gv !== 1'b1 || s_gid !== 2'd2 || s_en !== 1'b0) begin
            errors++;
            $display("FAIL early_drop_v%0d gv=%b id=%0d en=%b expected 1 2 0", v, s_gv, s_gid, s_en);
         end
         tick();
         checks++;
         if (s_gv !== 1'b0 || s_en !== 1'b0) begin
            errors++;
            $display("FAIL early_idle_v%0d gv=%b en=%b expected 0 0", v, s_gv, s_en);
         end
         tick();
         checks++;
         if (s_gv !== 1'b1 || s_gid !== nxt[v] || s_en !== 1'b1) begin
            errors++;
            $display("FAIL early_next_v%0d gv=%b id=%0d en=%b expected 1 %0d 1", v, s_gv, s_gid, s_en, nxt[v]);
         end
      end
      req_valid = '0;
   endtask

   task automatic test_reset_mid_burst();
      reset_dut();
      word[0]   = 4'd1;
      req_valid = 4'b0001;
      tick();
      tick();
      tick();
      wr_rst_n = 1'b0;
      tick();
      checks++;
      if (s_en !== 1'b0 || s_rdy !== 4'h0 || s_gv !== 1'b0 || s_gid !== 2'd0 || s_dat !== 4'h0) begin
         errors++;
         $display("FAIL midrst_hold en=%b rdy=%h gv=%b id=%0d dat=%h expected 0 0 0 0 0", s_en, s_rdy, s_gv, s_gid, s_dat);
      end
      wr_rst_n = 1'b1;
      tick();
      checks++;
      if (s_gv !== 1'b0 || s_en !== 1'b0) begin
         errors++;
         $display("FAIL midrst_idle gv=%b en=%b expected 0 0", s_gv, s_en);
      end
      tick();
      checks++;
      if (s_gv !== 1'b1 || s_gid !== 2'd0 || s_en !== 1'b1 || s_dat !== 4'd3) begin
         errors++;
         $display("FAIL midrst_regrant gv=%b id=%0d en=%b dat=%h expected 1 0 1 3", s_gv, s_gid, s_en, s_dat);
      end
      req_valid = '0;
   endtask

   initial begin
      test_reset();
      test_burst_limit();
      test_round_robin();
      test_full_stall();
      test_early_release();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
